// File: rtl/nios_mtl_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words
// and flags a mismatch or timeout against the build-time values.
module nios_mtl_sysid_checker #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1459509197,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic        AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);

    typedef enum logic [2:0] {
        IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        auto_q, auto_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] read_id_q, read_id_d;
    logic [31:0] read_ts_q, read_ts_d;
    logic        expire;
    logic        fail;

    assign expire = (cnt_q == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        auto_d    = 1'b0;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        read_id_d = read_id_q;
        read_ts_d = read_ts_q;
        fail      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start || auto_q) state_d = ID_REQ;
            end
            ID_REQ: begin
                if (!avm_waitrequest) state_d = ID_WAIT;
                else if (expire)      fail    = 1'b1;
            end
            ID_WAIT: begin
                if (avm_readdatavalid) begin
                    state_d   = TS_REQ;
                    read_id_d = avm_readdata;
                end else if (expire) begin
                    fail = 1'b1;
                end
            end
            TS_REQ: begin
                if (!avm_waitrequest) state_d = TS_WAIT;
                else if (expire)      fail    = 1'b1;
            end
            TS_WAIT: begin
                if (avm_readdatavalid) begin
                    state_d   = DONE;
                    read_ts_d = avm_readdata;
                    id_ok_d   = (read_id_q == EXPECTED_ID);
                    ts_ok_d   = (avm_readdata == EXPECTED_TS);
                end else if (expire) begin
                    fail = 1'b1;
                end
            end
            DONE: begin
                if (start) state_d = ID_REQ;
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
        end

        // Counter restarts on entry to each request; status clears on a new run.
        if (state_d == ID_REQ && state_q != ID_REQ) begin
            cnt_d     = 16'd0;
            addr_d    = BASE_ADDR;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            timeout_d = 1'b0;
        end else if (state_d == TS_REQ && state_q != TS_REQ) begin
            cnt_d  = 16'd0;
            addr_d = BASE_ADDR + 32'd4;
        end else if (state_q != IDLE && state_q != DONE) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            addr_q    <= BASE_ADDR;
            auto_q    <= AUTO_START;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            read_id_q <= 32'h0;
            read_ts_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            auto_q    <= auto_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            read_id_q <= read_id_d;
            read_ts_q <= read_ts_d;
        end
    end

    assign avm_read    = (state_q == ID_REQ) || (state_q == TS_REQ);
    assign avm_address = addr_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign read_id     = read_id_q;
    assign read_ts     = read_ts_q;

endmodule
